// File: rtl/route_table_loader_if.sv
// Host entry stream into the route table loader.
// Carries one routing entry per valid/ready handshake.
interface route_table_loader_if #(
  parameter int DEST_W = 4,
  parameter int PORT_W = 3
) ();
  logic              valid;
  logic              ready;
  logic [DEST_W-1:0] dest;
  logic [PORT_W-1:0] port;
  logic              last;

  modport master (
    output valid, dest, port, last,
    input  ready
  );

  modport slave (
    input  valid, dest, port, last,
    output ready
  );
endinterface

// File: rtl/route_table_loader.sv
// Route table loader: programs one router's table from a host entry stream.
// Optional fill pass writes DEFAULT_PORT to every entry first.
module route_table_loader #(
  parameter int ROUTERS_CNT        = 16,
  parameter int ROUTERS_CNT_BIN    = 4,
  parameter int IN_OUTPORT_CNT_BIN = 3,
  parameter int DEFAULT_PORT       = 0
) (
  input  logic                          i_clk,
  input  logic                          i_reset,
  input  logic                          i_start,
  input  logic                          i_fill_en,
  route_table_loader_if.slave           io_entry,
  output logic [ROUTERS_CNT_BIN-1:0]    o_load,
  output logic [IN_OUTPORT_CNT_BIN-1:0] o_data,
  output logic                          o_write,
  output logic                          o_init,
  output logic                          o_busy,
  output logic                          o_done,
  output logic                          o_err,
  output logic [7:0]                    o_wr_count
);

  localparam int RCB = ROUTERS_CNT_BIN;
  localparam int PCB = IN_OUTPORT_CNT_BIN;
  localparam logic [31:0]    LP_RC   = ROUTERS_CNT;
  localparam logic [RCB-1:0] LP_LAST = RCB'(ROUTERS_CNT - 1);
  localparam logic [PCB-1:0] LP_DEF  = PCB'(DEFAULT_PORT);

  // DRAIN is the slot holding the final entry's write; FINISH carries DONE.
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FILL,
    ST_STREAM,
    ST_DRAIN,
    ST_FINISH
  } state_t;

  state_t         r_state;
  logic [RCB-1:0] r_idx;
  logic [RCB-1:0] r_load;
  logic [PCB-1:0] r_data;
  logic           r_write;
  logic           r_init;
  logic           r_busy;
  logic           r_done;
  logic           r_err;
  logic           r_ready;
  logic [7:0]     r_cnt;

  logic           w_accept;
  logic           w_dest_ok;
  logic [7:0]     w_cnt_inc;

  assign w_accept  = io_entry.valid & r_ready;
  assign w_dest_ok = 32'(io_entry.dest) < LP_RC;
  assign w_cnt_inc = (r_cnt == 8'hFF) ? r_cnt : r_cnt + 8'd1;

  // Session FSM with all outputs registered.
  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      r_state <= ST_IDLE;
      r_idx   <= '0;
      r_load  <= '0;
      r_data  <= '0;
      r_write <= 1'b0;
      r_init  <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
      r_ready <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_write <= 1'b0;
      r_done  <= 1'b0;
      unique case (r_state)
        ST_IDLE: begin
          if (i_start) begin
            r_init <= 1'b1;
            r_busy <= 1'b1;
            r_err  <= 1'b0;
            r_cnt  <= '0;
            r_idx  <= '0;
            if (i_fill_en) begin
              r_state <= ST_FILL;
            end else begin
              r_state <= ST_STREAM;
              r_ready <= 1'b1;
            end
          end
        end
        ST_FILL: begin
          r_write <= 1'b1;
          r_load  <= r_idx;
          r_data  <= LP_DEF;
          r_cnt   <= w_cnt_inc;
          r_idx   <= r_idx + RCB'(1);
          if (r_idx == LP_LAST) begin
            r_state <= ST_STREAM;
            r_ready <= 1'b1;
          end
        end
        ST_STREAM: begin
          if (w_accept) begin
            if (w_dest_ok) begin
              r_write <= 1'b1;
              r_load  <= io_entry.dest;
              r_data  <= io_entry.port;
              r_cnt   <= w_cnt_inc;
            end else begin
              r_err <= 1'b1;
            end
            if (io_entry.last) begin
              r_ready <= 1'b0;
              r_state <= ST_DRAIN;
            end
          end
        end
        ST_DRAIN: begin
          r_init  <= 1'b0;
          r_busy  <= 1'b0;
          r_done  <= 1'b1;
          r_state <= ST_FINISH;
        end
        ST_FINISH: begin
          r_state <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign io_entry.ready = r_ready;
  assign o_load         = r_load;
  assign o_data         = r_data;
  assign o_write        = r_write;
  assign o_init         = r_init;
  assign o_busy         = r_busy;
  assign o_done         = r_done;
  assign o_err          = r_err;
  assign o_wr_count     = r_cnt;

endmodule
